// File: rtl/block_serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the nibble-serial subtractor.
// Slice width is fixed at 4 bits; the operand width is a parameter of the top.
`timescale 1ns/1ps
package block_serial_subtractor_pkg;

    localparam int BLOCK_W    = 4;
    localparam int N_DEFAULT  = 32;
    localparam int NUM_BLOCKS = N_DEFAULT / BLOCK_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_blocks(input int n);
        return n / BLOCK_W;
    endfunction

    // Slice counter needs at least one bit even when only one slice exists.
    function automatic int cnt_width(input int n);
        return (n / BLOCK_W > 1) ? $clog2(n / BLOCK_W) : 1;
    endfunction

endpackage

// File: rtl/block_serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor.
// Handshake: a transfer happens on the rising edge where valid && ready; valid never waits on ready.
`timescale 1ns/1ps
interface block_serial_subtractor_if
    import block_serial_subtractor_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
    logic         of;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, diff, borrow, of
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, diff, borrow, of
    );

endinterface

// File: rtl/block_serial_subtractor_sub_block_4_bit.sv
// One slice of the subtractor: d = a + ~b + cin, with the slice carry-out.
// A carry-out of 1 means no borrow was taken from this slice.
`timescale 1ns/1ps
module sub_block_4_bit
    import block_serial_subtractor_pkg::*;
(
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] d,
    output logic               cout
);

    assign {cout, d} = {1'b0, a} + {1'b0, ~b} + {{BLOCK_W{1'b0}}, cin};

endmodule

// File: rtl/block_serial_subtractor.sv
// Serial subtractor: one 4-bit slice per clock, LSB slice first, through a single shared slice unit.
// N must be a multiple of 4; the result appears N/4 edges after the operands are taken.
`timescale 1ns/1ps
module block_serial_subtractor
    import block_serial_subtractor_pkg::*;
#(
    parameter int N = N_DEFAULT
)(
    input  logic                     clk,
    input  logic                     rst,
    block_serial_subtractor_if.slave bus,
    output state_e                   state_o
);

    localparam int NB    = num_blocks(N);
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               carry_q,     carry_d;
    logic [N-1:0]       in1_q,       in1_d;
    logic [N-1:0]       in2_q,       in2_d;
    logic [N-1:0]       diff_q,      diff_d;
    logic               borrow_q,    borrow_d;
    logic               of_q,        of_d;
    logic               out_valid_q, out_valid_d;

    logic [BLOCK_W-1:0] slice_a;
    logic [BLOCK_W-1:0] slice_b;
    logic [BLOCK_W-1:0] slice_d;
    logic               slice_cout;

    assign slice_a = in1_q[int'(cnt_q) * BLOCK_W +: BLOCK_W];
    assign slice_b = in2_q[int'(cnt_q) * BLOCK_W +: BLOCK_W];

    sub_block_4_bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .d    (slice_d),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        of_d        = of_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    in1_d   = bus.in1;
                    in2_d   = bus.in2;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                diff_d[int'(cnt_q) * BLOCK_W +: BLOCK_W] = slice_d;
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    // Flags use the slice just computed, since diff_q has not taken it yet.
                    borrow_d    = ~slice_cout;
                    of_d        = (in1_q[N-1] != in2_q[N-1]) &&
                                  (slice_d[BLOCK_W-1] != in1_q[N-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            of_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            of_q        <= of_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.of        = of_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Bench for block_serial_subtractor: directed corner cases, hold/abort scenarios and a random run,
// with results checked against an arithmetic reference model through an expected queue.
`timescale 1ns/1ps
module tb_block_serial_subtractor;
    import block_serial_subtractor_pkg::*;

    localparam int N  = N_DEFAULT;
    localparam int NB = N / BLOCK_W;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_e state_dbg;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_serial_subtractor_if #(.N(N)) bus ();

    block_serial_subtractor #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int           compared   = 0;
    int           mismatched = 0;
    logic [N+1:0] exp_q[$];
    longint       accept_edge = 0;
    bit           rand_done;

    // Reference: plain modular arithmetic; overflow means the signed difference does not fit in N bits.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        logic         br;
        logic         ov;
        longint       sd;
        d  = a - b;
        br = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd != longint'($signed(d)));
        return {d, br, ov};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        int budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        @(negedge clk);
        while (!bus.in_ready && budget < 300) begin
            budget++;
            @(negedge clk);
        end
        if (bus.in_ready) begin
            exp_q.push_back(model(a, b));
        end else begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in1      = $urandom;
        bus.in2      = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pick_operand();
        logic [N-1:0] corners [4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = {1'b1, {(N-1){1'b0}}};
        corners[3] = {1'b0, {(N-1){1'b1}}};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [N+1:0] exp;
        bit prev_hs;
        bit ovalid_prev;
        prev_hs     = 1'b0;
        ovalid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hs     = 1'b0;
                ovalid_prev = 1'b0;
            end else begin
                if (prev_hs)
                    check("ready_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
                if (bus.in_valid && bus.in_ready)
                    accept_edge = cyc + 1;
                if (bus.out_valid && !ovalid_prev)
                    check("latency", 64'(cyc - accept_edge), 64'(NB));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_result: got diff 0x%0h with no pending operation", bus.diff);
                    end else begin
                        exp = exp_q.pop_front();
                        check("result", 64'({bus.diff, bus.borrow, bus.of}), 64'(exp));
                    end
                end
                prev_hs     = bus.out_valid && bus.out_ready;
                ovalid_prev = bus.out_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N+3:0] zero_state;
        logic [N+1:0] hold_exp;
        logic [N-1:0] ha;
        logic [N-1:0] hb;
        int           n;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in1       = 32'h1234_5678;
        bus.in2       = 32'h0000_0001;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        // Reset state: {in_ready, out_valid, diff, borrow, of}
        zero_state = {1'b1, 1'b0, {N{1'b0}}, 2'b00};
        @(negedge clk);
        check("reset_outputs", 64'({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.of}), 64'(zero_state));
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        @(posedge clk);
        #1;

        // Directed corner vectors with the consumer always ready.
        bus.out_ready = 1'b1;
        send(32'd5, 32'd3);
        wait_drain();
        send(32'd0, 32'd1);
        wait_drain();
        send(32'h8000_0000, 32'h0000_0001);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        wait_drain();

        // Result held while the consumer stalls; in_valid pulsed mid-calculation must be ignored.
        bus.out_ready = 1'b0;
        ha = 32'hDEAD_BEEF;
        hb = 32'h1234_5678;
        hold_exp = model(ha, hb);
        send(ha, hb);
        bus.in_valid = 1'b1;
        bus.in1      = 32'h0000_0001;
        bus.in2      = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_stable", 64'({bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.of}),
                  64'({1'b1, 1'b0, hold_exp}));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Abort in CALC with the slice counter at 3, then confirm a clean restart.
        send(32'hCAFE_F00D, 32'h0BAD_CAFE);
        repeat (3) @(posedge clk);
        #1;
        check("calc_before_abort", 64'(state_dbg), 64'(CALC));
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in1      = 32'h0000_00FF;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_outputs", 64'({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.of}), 64'(zero_state));
        @(posedge clk);
        #1;
        send(32'h0000_1000, 32'h0000_0FFF);
        wait_drain();

        // Random back-to-back run with a randomly stalling consumer.
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick_operand(), pick_operand());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/block_serial_subtractor.md
BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 Parameter: N, default 32, operand width; SHALL be a multiple of 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair present on in1/in2.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in1  input  N  minuend.
REQ-007 in2  input  N  subtrahend.
REQ-008 out_valid  output  1  diff/borrow/of hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  N  in1 - in2, modulo 2^N.
REQ-011 borrow  output  1  1 when unsigned in1 < in2.
REQ-012 of  output  1  signed two's-complement overflow flag.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; the block SHALL accept operands on the edge where in_valid && in_ready.
REQ-015 On acceptance, the block SHALL register in1 and in2, set block counter cnt=0, preset carry=1, and go to CALC.
REQ-016 CALC: in_ready=0; on each edge the block SHALL compute 4-bit slice cnt as in1_slice + ~in2_slice + carry, store the slice into diff_reg, update carry with the slice carry-out, and increment cnt.
REQ-017 cnt SHALL be ceil(log2(N/4)) bits wide; after slice N/4-1 is stored, the FSM SHALL go to DONE rather than wrap.
REQ-018 Latency: out_valid SHALL rise exactly N/4 edges after the acceptance edge (8 for N=32).
REQ-019 On entering DONE, the block SHALL set borrow = ~final_carry and of = (in1[N-1] != in2[N-1]) && (diff[N-1] != in1[N-1]) from the registered operands.
REQ-020 DONE: out_valid=1; diff, borrow and of SHALL remain stable until the edge where out_valid && out_ready.
REQ-021 On the edge where out_valid && out_ready, the FSM SHALL return to IDLE; in_ready SHALL be 1 in the following cycle (no same-cycle result and accept).
REQ-022 in_valid in CALC or DONE SHALL be ignored; in1/in2 changes after acceptance SHALL NOT affect the result.
REQ-023 If out_ready is held high before DONE, the result SHALL be presented for exactly one cycle.
REQ-024 Outputs diff, borrow, of and out_valid SHALL be registered; there SHALL be no combinational path from inputs to outputs except in_ready, which derives from state.

Reset
REQ-025 When rst=1 at an edge, the FSM SHALL go to IDLE, with cnt=0, carry=0, diff=0, borrow=0, of=0, out_valid=0, and in_ready=1 after that edge.
REQ-026 Reset in CALC or DONE SHALL abort the operation and discard the partial result; in_valid during reset SHALL be ignored.

Structure
REQ-027 A shared package/include SHALL hold BLOCK_W=4, NUM_BLOCKS=N/BLOCK_W, and the FSM state encodings IDLE/CALC/DONE.
REQ-028 The 4-bit slice arithmetic SHALL be one sub-module, sub_block_4_bit (a, b, cin -> d, cout; computes a + ~b + cin), instantiated once and time-multiplexed over the slices.
REQ-029 The top level SHALL contain only the FSM, the counter, the operand/result registers and the flag logic.

Verification
REQ-030 Accept in1=5, in2=3 -> out_valid after 8 edges; diff=0x00000002, borrow=0, of=0.
REQ-031 in1=0, in2=1 -> diff=0xFFFFFFFF, borrow=1, of=0.
REQ-032 in1=0x80000000, in2=1 -> diff=0x7FFFFFFF, borrow=0, of=1; in1=0x7FFFFFFF, in2=0xFFFFFFFF -> diff=0x80000000, borrow=1, of=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; pulse in_valid with other operands in CALC -> result unchanged.
REQ-034 Assert rst in CALC at cnt=3 -> next cycle all outputs 0, in_ready=1; a new operation then completes correctly.
REQ-035 Run back-to-back random operations (1000 pairs, random out_ready) -> every result matches the reference model, and in_ready rises one cycle after each result handshake.
